// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - slot scanner driving a 2-to-4 decoder select.
// Optional pause input enabled by defining SCAN_SEQ_PAUSE_EN.
module scan_sequencer #(
  parameter int PRESCALE = 4,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
`ifdef SCAN_SEQ_PAUSE_EN
  input  logic       pause,
`endif
  input  logic [3:0] mask,
  output logic [1:0] sel,
  output logic       valid,
  output logic       busy,
  output logic       wrap
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  state_t           state_q;
  logic [1:0]       sel_q;
  logic             valid_q;
  logic             busy_q;
  logic             wrap_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       mask_q;

  logic [1:0]       adv_sel_d;
  logic             adv_found_d;
  logic             adv_wrap_d;
  logic [1:0]       low_sel_d;
  logic             pause_w;

`ifdef SCAN_SEQ_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  // Next active slot after sel_q in latched-mask order; sel+4 lands back on sel.
  always_comb begin
    logic [1:0] idx;
    adv_sel_d   = sel_q;
    adv_found_d = 1'b0;
    idx         = sel_q;
    for (int k = 1; k <= 4; k++) begin
      idx = sel_q + 2'(k);
      if (!adv_found_d && mask_q[idx]) begin
        adv_sel_d   = idx;
        adv_found_d = 1'b1;
      end
    end
    adv_wrap_d = (adv_sel_d <= sel_q);
  end

  always_comb begin
    low_sel_d = 2'd0;
    if (mask[0])      low_sel_d = 2'd0;
    else if (mask[1]) low_sel_d = 2'd1;
    else if (mask[2]) low_sel_d = 2'd2;
    else if (mask[3]) low_sel_d = 2'd3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
      mask_q  <= 4'd0;
    end else begin
      wrap_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !stop && (mask != 4'd0)) begin
            mask_q  <= mask;
            sel_q   <= low_sel_d;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (stop) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (pause_w) begin
            cnt_q <= cnt_q;
          end else if (cnt_q != CNT_LAST) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            cnt_q <= '0;
            if (adv_wrap_d) begin
              // Sweep boundary: the only point where a new mask is accepted.
              wrap_q <= 1'b1;
              mask_q <= mask;
              if (mask == 4'd0) begin
                state_q <= IDLE;
                sel_q   <= 2'd0;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
              end else begin
                sel_q <= low_sel_d;
              end
            end else begin
              sel_q <= adv_sel_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sel   = sel_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// tb/tb_scan_sequencer.sv - directed self-checking bench for scan_sequencer.
module tb_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       pause;
  logic [3:0] mask;
  logic [1:0] sel;
  logic       valid;
  logic       busy;
  logic       wrap;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  scan_sequencer #(.PRESCALE(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .stop  (stop),
`ifdef SCAN_SEQ_PAUSE_EN
    .pause (pause),
`endif
    .mask  (mask),
    .sel   (sel),
    .valid (valid),
    .busy  (busy),
    .wrap  (wrap)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [1:0] e_sel, input logic e_valid,
                            input logic e_busy, input logic e_wrap);
    logic [4:0] obs;
    logic [4:0] exp;
    obs = {sel, valid, busy, wrap};
    exp = {e_sel, e_valid, e_busy, e_wrap};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed sel/valid/busy/wrap=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic start_run(input logic [3:0] m);
    mask  = m;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic stop_run();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    pause = 1'b0;
    mask  = 4'd0;

    // Reset held for three clocks
    step(); step(); step();
    expect_out("reset", 2'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    expect_out("post_reset_idle", 2'd0, 1'b0, 1'b0, 1'b0);

    // Full mask sweep, PRESCALE=4
    start_run(4'b1111);
    for (int c = 1; c <= 20; c++) begin
      expect_out($sformatf("sweep_f_c%0d", c), 2'((c - 1) / 4), 1'b1, 1'b1, (c == 17));
      step();
    end
    stop_run();
    expect_out("sweep_f_stopped", 2'd0, 1'b0, 1'b0, 1'b0);

    // Sparse mask 1010
    start_run(4'b1010);
    for (int c = 1; c <= 12; c++) begin
      expect_out($sformatf("mask_a_c%0d", c), (((c - 1) / 4) % 2 == 1) ? 2'd3 : 2'd1,
                 1'b1, 1'b1, (c == 9));
      step();
    end
    stop_run();

    // Single active slot: wrap every 4th clock
    start_run(4'b0100);
    for (int c = 1; c <= 12; c++) begin
      expect_out($sformatf("mask_4_c%0d", c), 2'd2, 1'b1, 1'b1, (c == 5 || c == 9));
      step();
    end
    stop_run();
    expect_out("mask_4_stopped", 2'd0, 1'b0, 1'b0, 1'b0);

    // start with empty mask is ignored
    start_run(4'b0000);
    expect_out("empty_mask_start", 2'd0, 1'b0, 1'b0, 1'b0);
    step();
    expect_out("empty_mask_start_hold", 2'd0, 1'b0, 1'b0, 1'b0);

    // Mask cleared mid-sweep takes effect at the wrap
    start_run(4'b1111);
    for (int c = 1; c <= 18; c++) begin
      if (c < 17)
        expect_out($sformatf("drain_c%0d", c), 2'((c - 1) / 4), 1'b1, 1'b1, 1'b0);
      else if (c == 17)
        expect_out("drain_wrap_exit", 2'd0, 1'b0, 1'b0, 1'b1);
      else
        expect_out("drain_idle", 2'd0, 1'b0, 1'b0, 1'b0);
      if (c == 6) mask = 4'b0000;
      step();
    end

    // start in RUN ignored; stop at cycle 7
    start_run(4'b1111);
    for (int c = 1; c <= 7; c++) begin
      expect_out($sformatf("stop_run_c%0d", c), 2'((c - 1) / 4), 1'b1, 1'b1, 1'b0);
      start = (c == 3);
      stop  = (c == 7);
      step();
    end
    start = 1'b0;
    stop  = 1'b0;
    expect_out("stop_c8", 2'd0, 1'b0, 1'b0, 1'b0);

    // start+stop together in IDLE
    mask  = 4'b1111;
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    expect_out("start_stop_idle", 2'd0, 1'b0, 1'b0, 1'b0);

    // Restart after stop begins from a fresh dwell
    start_run(4'b0110);
    for (int c = 1; c <= 5; c++) begin
      expect_out($sformatf("restart_c%0d", c), (c <= 4) ? 2'd1 : 2'd2, 1'b1, 1'b1, 1'b0);
      step();
    end

    // Asynchronous reset mid-dwell, away from the clock edge
    #3;
    rst_n = 1'b0;
    #1;
    expect_out("async_reset", 2'd0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    step();
    expect_out("async_reset_release", 2'd0, 1'b0, 1'b0, 1'b0);

`ifdef SCAN_SEQ_PAUSE_EN
    // Pause freezes the dwell counter
    start_run(4'b1111);
    for (int c = 1; c <= 12; c++) begin
      expect_out($sformatf("pause_c%0d", c), (c <= 10) ? 2'd0 : 2'd1, 1'b1, 1'b1, 1'b0);
      pause = (c >= 3 && c <= 8);
      step();
    end
    pause = 1'b1;
    stop  = 1'b1;
    step();
    pause = 1'b0;
    stop  = 1'b0;
    expect_out("stop_during_pause", 2'd0, 1'b0, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
